imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the instruction ROM read port: receives a program image as a byte
//  stream (e.g. from a UART receiver), packs it into 32-bit little-endian words and drives a
//  synchronous write port into instruction memory. Holds the CPU in reset (CpuHold) until a
//  complete image with a valid checksum has been written.
//  Stream format: 4-byte word count N (LE), N*4 payload bytes (LE words), 1-byte XOR checksum.
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  byte address of first written word
//  MAX_WORDS   1048576        largest accepted N (instruction memory depth in words)
//  CNT_W       21             width of word counters; must hold MAX_WORDS
// PORTS
//  clk            in   1      single clock, all logic on rising edge
//  rst_n          in   1      synchronous reset, active-low
//  RxData         in   8      stream byte
//  RxValid        in   1      RxData valid
//  RxReady        out  1      loader can accept; byte taken when RxValid&&RxReady at posedge
//  Restart        in   1      abort/restart load (level, sampled each cycle)
//  MemWriteEnable out  1      one-cycle write strobe to instruction memory
//  MemAddress     out  32     byte address of write (word aligned)
//  MemWriteData   out  32     word to write
//  WordsLoaded    out  CNT_W  words written in current load
//  LoadDone       out  1      image loaded, checksum OK (sticky)
//  LoadError      out  1      N > MAX_WORDS or checksum mismatch (sticky)
//  CpuHold        out  1      1 = keep CPU in reset
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state RECV_LEN, MemWriteEnable=0, MemAddress=BASE_ADDR,
//   MemWriteData=0, WordsLoaded=0, LoadDone=0, LoadError=0, CpuHold=1, byte index/csum=0.
//  States: RECV_LEN -> RECV_DATA -> RECV_CSUM -> DONE | ERROR.
//  RxReady = (state in RECV_LEN/RECV_DATA/RECV_CSUM) && !Restart; combinational, no bubbles:
//   one byte may be accepted every cycle.
//  RECV_LEN: 4 bytes form N (first byte = bits 7:0). On 4th byte: N > MAX_WORDS -> ERROR;
//   N == 0 -> RECV_CSUM; else RECV_DATA.
//  RECV_DATA: byte k of word i goes to bits 8k+7:8k; csum ^= byte. On 4th byte of word i,
//   next cycle: MemWriteEnable=1, MemAddress=BASE_ADDR+4*i (32-bit wrap),
//   MemWriteData=packed word, WordsLoaded=i+1. Strobe is exactly one cycle; back-to-back
//   words give a strobe every 4th cycle. After word N-1 -> RECV_CSUM.
//  RECV_CSUM: 1 byte. Equal to csum -> DONE: LoadDone=1, CpuHold=0 next cycle.
//   Unequal -> ERROR: LoadError=1, CpuHold stays 1. XOR covers payload bytes only.
//  DONE/ERROR: RxReady=0, outputs held; incoming bytes ignored.
//  Restart=1 in any state: next cycle RECV_LEN, byte index/csum/WordsLoaded cleared,
//   LoadDone=LoadError=0, CpuHold=1, MemWriteEnable=0 (a strobe already due that cycle is
//   suppressed). Words already written stay in memory; partial word discarded.
//   Restart beats a simultaneous byte (RxReady is low).
//  rst_n mid-load: same as reset; memory contents untouched.
//  MemAddress/MemWriteData are don't-care when MemWriteEnable=0 but hold last value.
// TESTING
//  1. Stream 01 00 00 00 | 13 00 00 00 | 13 -> one strobe, Addr=0x0, Data=0x00000013,
//     LoadDone=1, CpuHold=0, WordsLoaded=1.
//  2. N=2, words 0xDEADBEEF,0x00500093 (LE bytes), csum=XOR of 8 bytes, RxValid held high
//     -> strobes 4 cycles apart at 0x0,0x4; data match; LoadDone=1.
//  3. Same as 1 with csum byte 0x12 -> no LoadDone, LoadError=1, CpuHold=1, RxReady=0.
//  4. N bytes 01 00 10 00 (0x100001 > MAX_WORDS) -> ERROR on 4th byte, no strobe.
//  5. N=0 then csum 00 -> LoadDone=1, no strobe; N=0, csum 01 -> LoadError=1.
//  6. N=3, Restart after 6 payload bytes, then full image N=1 -> first load: 1 strobe;
//     after Restart WordsLoaded=0, new strobe at 0x0; random RxValid gaps give same result.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs LE bytes into 32-bit words and writes them to instruction memory.
// Latency: write strobe one cycle after the 4th byte of a word; LoadDone one cycle after the checksum byte.
// Backpressure: RxReady is combinational, high in the receive states unless Restart; one byte per cycle.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1048576,
    parameter int          CNT_W     = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       RxData,
    input  logic             RxValid,
    output logic             RxReady,
    input  logic             Restart,
    output logic             MemWriteEnable,
    output logic [31:0]      MemAddress,
    output logic [31:0]      MemWriteData,
    output logic [CNT_W-1:0] WordsLoaded,
    output logic             LoadDone,
    output logic             LoadError,
    output logic             CpuHold
);

    typedef enum logic [2:0] {
        RECV_LEN,
        RECV_DATA,
        RECV_CSUM,
        DONE,
        ERROR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        byte_idx;
    logic [23:0]       len_buf;
    logic [23:0]       word_buf;
    logic [7:0]        csum;
    logic [CNT_W-1:0]  word_idx;
    logic [CNT_W-1:0]  word_idx_inc;
    logic [CNT_W-1:0]  num_words;
    logic [31:0]       n_full;
    logic              take;
    logic              last_byte;
    logic              n_too_big;

    assign RxReady      = ((state == RECV_LEN) || (state == RECV_DATA) || (state == RECV_CSUM)) && !Restart;
    assign take         = RxValid && RxReady;
    assign last_byte    = (byte_idx == 2'd3);
    assign n_full       = {RxData, len_buf};
    assign n_too_big    = (n_full > MAX_WORDS);
    assign word_idx_inc = word_idx + CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RECV_LEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; Restart has priority over any accepted byte
    always_comb begin
        state_nxt = state;
        if (Restart) begin
            state_nxt = RECV_LEN;
        end else if (take) begin
            case (state)
                RECV_LEN: begin
                    if (last_byte) begin
                        if (n_too_big)
                            state_nxt = ERROR;
                        else if (n_full == 32'd0)
                            state_nxt = RECV_CSUM;
                        else
                            state_nxt = RECV_DATA;
                    end
                end
                RECV_DATA: begin
                    if (last_byte && (word_idx_inc == num_words))
                        state_nxt = RECV_CSUM;
                end
                RECV_CSUM: begin
                    state_nxt = (RxData == csum) ? DONE : ERROR;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Byte packing, checksum, memory write port and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx       <= 2'd0;
            len_buf        <= 24'd0;
            word_buf       <= 24'd0;
            csum           <= 8'd0;
            word_idx       <= '0;
            num_words      <= '0;
            MemWriteEnable <= 1'b0;
            MemAddress     <= BASE_ADDR;
            MemWriteData   <= 32'd0;
            WordsLoaded    <= '0;
            LoadDone       <= 1'b0;
            LoadError      <= 1'b0;
            CpuHold        <= 1'b1;
        end else if (Restart) begin
            // Already-written words stay in memory; any partial word is dropped
            byte_idx       <= 2'd0;
            csum           <= 8'd0;
            word_idx       <= '0;
            WordsLoaded    <= '0;
            MemWriteEnable <= 1'b0;
            LoadDone       <= 1'b0;
            LoadError      <= 1'b0;
            CpuHold        <= 1'b1;
        end else begin
            MemWriteEnable <= 1'b0;
            if (take) begin
                case (state)
                    RECV_LEN: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    len_buf[7:0]   <= RxData;
                            2'd1:    len_buf[15:8]  <= RxData;
                            2'd2:    len_buf[23:16] <= RxData;
                            default: begin
                                num_words <= n_full[CNT_W-1:0];
                                if (n_too_big)
                                    LoadError <= 1'b1;
                            end
                        endcase
                    end
                    RECV_DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        csum     <= csum ^ RxData;
                        case (byte_idx)
                            2'd0:    word_buf[7:0]   <= RxData;
                            2'd1:    word_buf[15:8]  <= RxData;
                            2'd2:    word_buf[23:16] <= RxData;
                            default: begin
                                MemWriteEnable <= 1'b1;
                                MemAddress     <= BASE_ADDR + (32'(word_idx) << 2);
                                MemWriteData   <= {RxData, word_buf};
                                WordsLoaded    <= word_idx_inc;
                                word_idx       <= word_idx_inc;
                            end
                        endcase
                    end
                    RECV_CSUM: begin
                        if (RxData == csum) begin
                            LoadDone <= 1'b1;
                            CpuHold  <= 1'b0;
                        end else begin
                            LoadError <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stream images byte by byte and check strobes and status flags.
// Expected values are hand-computed constants; write strobes are captured at the falling edge.
// Inputs change 1 time unit after the rising edge; checks sample at the same point.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;
    logic        Restart;
    logic        MemWriteEnable;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic [20:0] WordsLoaded;
    logic        LoadDone;
    logic        LoadError;
    logic        CpuHold;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit gaps   = 1'b0;

    logic [31:0] st_addr[$];
    logic [31:0] st_data[$];
    int          st_cyc[$];

    imem_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RxData         (RxData),
        .RxValid        (RxValid),
        .RxReady        (RxReady),
        .Restart        (Restart),
        .MemWriteEnable (MemWriteEnable),
        .MemAddress     (MemAddress),
        .MemWriteData   (MemWriteData),
        .WordsLoaded    (WordsLoaded),
        .LoadDone       (LoadDone),
        .LoadError      (LoadError),
        .CpuHold        (CpuHold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (MemWriteEnable === 1'b1) begin
            st_addr.push_back(MemAddress);
            st_data.push_back(MemWriteData);
            st_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gaps) begin
            n = $urandom_range(0, 3);
            RxValid = 1'b0;
            repeat (n) @(posedge clk);
            #1;
        end
        RxData  = b;
        RxValid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        RxValid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        RxValid = 1'b0;
        Restart = 1'b1;
        #1;
        chk("restart_rdy_low", 32'(RxReady), 32'd0);
        @(posedge clk);
        #1;
        Restart = 1'b0;
        st_addr.delete();
        st_data.delete();
        st_cyc.delete();
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    // N=3 interrupted after 6 payload bytes, then a complete N=1 image
    task automatic restart_scenario(input string tag);
        send_word(32'd3);
        send_word(32'h44332211);
        idle(1);
        chk({tag, "_first_strobes"}, 32'(st_addr.size()), 32'd1);
        chk({tag, "_first_wl"}, 32'(WordsLoaded), 32'd1);
        send_byte(8'h55);
        send_byte(8'h66);
        do_restart();
        chk({tag, "_rst_wl"}, 32'(WordsLoaded), 32'd0);
        chk({tag, "_rst_done"}, 32'(LoadDone), 32'd0);
        chk({tag, "_rst_hold"}, 32'(CpuHold), 32'd1);
        send_word(32'd1);
        send_word(32'hAABBCCDD);
        send_byte(8'h00);
        idle(1);
        chk({tag, "_strobes"}, 32'(st_addr.size()), 32'd1);
        chk({tag, "_addr"}, st_addr[0], 32'h0);
        chk({tag, "_data"}, st_data[0], 32'hAABBCCDD);
        chk({tag, "_wl"}, 32'(WordsLoaded), 32'd1);
        chk({tag, "_done"}, 32'(LoadDone), 32'd1);
        chk({tag, "_hold"}, 32'(CpuHold), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        RxData  = 8'h00;
        RxValid = 1'b0;
        Restart = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(MemWriteEnable), 32'd0);
        chk("rst_addr", MemAddress, 32'h0);
        chk("rst_data", MemWriteData, 32'h0);
        chk("rst_wl", 32'(WordsLoaded), 32'd0);
        chk("rst_done", 32'(LoadDone), 32'd0);
        chk("rst_err", 32'(LoadError), 32'd0);
        chk("rst_hold", 32'(CpuHold), 32'd1);
        chk("rst_rdy", 32'(RxReady), 32'd1);
        rst_n = 1'b1;

        // 1: single word image
        send_word(32'd1);
        send_word(32'h00000013);
        chk("t1_we", 32'(MemWriteEnable), 32'd1);
        chk("t1_addr", MemAddress, 32'h0);
        chk("t1_data", MemWriteData, 32'h00000013);
        chk("t1_wl", 32'(WordsLoaded), 32'd1);
        send_byte(8'h13);
        chk("t1_we_single", 32'(MemWriteEnable), 32'd0);
        chk("t1_done", 32'(LoadDone), 32'd1);
        chk("t1_hold", 32'(CpuHold), 32'd0);
        chk("t1_rdy", 32'(RxReady), 32'd0);
        chk("t1_strobes", 32'(st_addr.size()), 32'd1);
        send_byte(8'hFF);
        idle(1);
        chk("t1_ignored", 32'(st_addr.size()), 32'd1);
        chk("t1_done_sticky", 32'(LoadDone), 32'd1);

        // 2: two words back-to-back, checksum EF^BE^AD^DE^93^00^50^00 = E1
        do_restart();
        chk("t2_restart_done", 32'(LoadDone), 32'd0);
        send_word(32'd2);
        send_word(32'hDEADBEEF);
        send_word(32'h00500093);
        send_byte(8'hE1);
        idle(1);
        chk("t2_strobes", 32'(st_addr.size()), 32'd2);
        chk("t2_addr0", st_addr[0], 32'h0);
        chk("t2_data0", st_data[0], 32'hDEADBEEF);
        chk("t2_addr1", st_addr[1], 32'h4);
        chk("t2_data1", st_data[1], 32'h00500093);
        chk("t2_spacing", 32'(st_cyc[1] - st_cyc[0]), 32'd4);
        chk("t2_wl", 32'(WordsLoaded), 32'd2);
        chk("t2_done", 32'(LoadDone), 32'd1);
        chk("t2_err", 32'(LoadError), 32'd0);

        // 3: bad checksum
        do_restart();
        send_word(32'd1);
        send_word(32'h00000013);
        send_byte(8'h12);
        chk("t3_done", 32'(LoadDone), 32'd0);
        chk("t3_err", 32'(LoadError), 32'd1);
        chk("t3_hold", 32'(CpuHold), 32'd1);
        chk("t3_rdy", 32'(RxReady), 32'd0);

        // 4: N above MAX_WORDS, then N exactly MAX_WORDS accepted
        do_restart();
        send_word(32'h00100001);
        chk("t4_err", 32'(LoadError), 32'd1);
        chk("t4_rdy", 32'(RxReady), 32'd0);
        idle(2);
        chk("t4_strobes", 32'(st_addr.size()), 32'd0);
        do_restart();
        send_word(32'h00100000);
        chk("t4_max_err", 32'(LoadError), 32'd0);
        chk("t4_max_rdy", 32'(RxReady), 32'd1);

        // 5: empty image, good and bad checksum
        do_restart();
        send_word(32'd0);
        send_byte(8'h00);
        idle(1);
        chk("t5_done", 32'(LoadDone), 32'd1);
        chk("t5_strobes", 32'(st_addr.size()), 32'd0);
        do_restart();
        send_word(32'd0);
        send_byte(8'h01);
        chk("t5_err", 32'(LoadError), 32'd1);
        chk("t5_err_done", 32'(LoadDone), 32'd0);

        // 6: restart mid-load, without and with RxValid gaps
        do_restart();
        restart_scenario("t6");
        do_restart();
        gaps = 1'b1;
        restart_scenario("t6g");
        gaps = 1'b0;

        // Restart coinciding with the 4th byte of a word suppresses the write
        do_restart();
        send_word(32'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        RxData  = 8'h04;
        RxValid = 1'b1;
        Restart = 1'b1;
        @(posedge clk);
        #1;
        Restart = 1'b0;
        RxValid = 1'b0;
        chk("rs_we", 32'(MemWriteEnable), 32'd0);
        chk("rs_wl", 32'(WordsLoaded), 32'd0);
        idle(1);
        chk("rs_strobes", 32'(st_addr.size()), 32'd0);

        // Reset mid-load
        send_word(32'd2);
        send_byte(8'hAA);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mrst_addr", MemAddress, 32'h0);
        chk("mrst_hold", 32'(CpuHold), 32'd1);
        chk("mrst_rdy", 32'(RxReady), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
